dct_quant_serializer: RTL and testbench

DCT_QUANT_SERIALIZER -- requirements
Module: dct_quant_serializer

---
 rtl/dct_quant_serializer_if.sv | 26 ++
 rtl/dct_quant_serializer.sv | 112 +++++++++++
 tb/tb_dct_quant_serializer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dct_quant_serializer_if.sv
// Row-in / coefficient-out handshake bundle for dct_quant_serializer.
// The slave modport is the serializer's view and the master modport is the upstream/downstream view.
interface dct_quant_serializer_if #(
  parameter int IN_WORD_SIZE  = 15,
  parameter int OUT_WORD_SIZE = 8
);
  logic                            in_valid;
  logic                            in_ready;
  logic signed [IN_WORD_SIZE-1:0]  z0, z1, z2, z3, z4, z5, z6, z7;
  logic        [3:0]               q_shift;
  logic                            out_valid;
  logic                            out_ready;
  logic signed [OUT_WORD_SIZE-1:0] out_data;
  logic        [2:0]               out_idx;
  logic                            out_last;

  modport master (
    output in_valid, z0, z1, z2, z3, z4, z5, z6, z7, q_shift, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last
  );

  modport slave (
    input  in_valid, z0, z1, z2, z3, z4, z5, z6, z7, q_shift, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last
  );
endinterface

// File: rtl/dct_quant_serializer.sv
// Captures a row of eight DCT coefficients, then emits them one per handshake
// as rounded, right-shifted and saturated values in index order 0..7.
module dct_quant_serializer #(
  parameter int IN_WORD_SIZE  = 15,
  parameter int OUT_WORD_SIZE = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  dct_quant_serializer_if.slave   bus
);

  localparam int W = IN_WORD_SIZE + 1;
  localparam logic signed [W-1:0] QMAX = W'((2 ** (OUT_WORD_SIZE - 1)) - 1);
  localparam logic signed [W-1:0] QMIN = ~QMAX;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                         state_q, state_d;
  logic [2:0]                     idx_q, idx_d;
  logic signed [IN_WORD_SIZE-1:0] row_q [8];
  logic signed [IN_WORD_SIZE-1:0] row_d [8];
  logic [3:0]                     shift_q, shift_d;

  logic                           in_ready;
  logic                           out_valid;
  logic                           accept;
  logic                           handoff;
  logic signed [W-1:0]            sel;
  logic signed [W-1:0]            rnd;
  logic signed [W-1:0]            res;
  logic signed [OUT_WORD_SIZE-1:0] q_data;

  // State register; the row buffer is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk) begin
    row_q   <= row_d;
    shift_q <= shift_d;
  end

  // Next-state: the idx-7 handoff may capture the following row in the same cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    row_d   = row_q;
    shift_d = shift_q;
    if (accept) begin
      row_d   = '{bus.z0, bus.z1, bus.z2, bus.z3, bus.z4, bus.z5, bus.z6, bus.z7};
      shift_d = bus.q_shift;
    end
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
        if (handoff) begin
          if (idx_q == 3'd7) begin
            state_d = accept ? SEND : IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Quantizer: round-half-up then arithmetic shift; the extra bit absorbs the rounding add.
  always_comb begin
    sel = W'(row_q[idx_q]);
    rnd = '0;
    res = sel;
    if (shift_q != 4'd0) begin
      rnd = W'(1) << (shift_q - 4'd1);
      res = (sel + rnd) >>> shift_q;
    end
    if (res > QMAX)
      q_data = QMAX[OUT_WORD_SIZE-1:0];
    else if (res < QMIN)
      q_data = QMIN[OUT_WORD_SIZE-1:0];
    else
      q_data = res[OUT_WORD_SIZE-1:0];
  end

  always_comb begin
    out_valid     = (state_q == SEND);
    in_ready      = (state_q == IDLE) || (idx_q == 3'd7 && bus.out_ready);
    accept        = bus.in_valid && in_ready;
    handoff       = out_valid && bus.out_ready;
    bus.in_ready  = in_ready;
    bus.out_valid = out_valid;
    bus.out_data  = out_valid ? q_data : '0;
    bus.out_idx   = out_valid ? idx_q : '0;
    bus.out_last  = out_valid && (idx_q == 3'd7);
  end

endmodule

// File: tb/tb_dct_quant_serializer.sv
// Directed bench for dct_quant_serializer: expected coefficients are queued on
// row acceptance and compared as each coefficient is handed off.
module tb_dct_quant_serializer;

  localparam int IW = 15;
  localparam int OW = 8;

  typedef struct {
    int data;
    int idx;
    int last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [IW-1:0] zr [8];
  logic [3:0] sr = '0;

  exp_t sb [$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   accepted = 0;

  dct_quant_serializer_if #(.IN_WORD_SIZE(IW), .OUT_WORD_SIZE(OW)) bus ();

  dct_quant_serializer #(.IN_WORD_SIZE(IW), .OUT_WORD_SIZE(OW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.z0 = zr[0];
  assign bus.z1 = zr[1];
  assign bus.z2 = zr[2];
  assign bus.z3 = zr[3];
  assign bus.z4 = zr[4];
  assign bus.z5 = zr[5];
  assign bus.z6 = zr[6];
  assign bus.z7 = zr[7];
  assign bus.q_shift = sr;

  always #5 clk = ~clk;

  function automatic int q_model(input int v, input int s);
    int r;
    if (s == 0) r = v;
    else        r = (v + (1 << (s - 1))) >>> s;
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    return r;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    vectors++;
    miscompares++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  // One clock: sample just before the edge, score handshakes, return at edge+1.
  task automatic cycle();
    exp_t e;
    accepted = 0;
    @(negedge clk);
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_output");
        end else begin
          e = sb.pop_front();
          chk("out_data", 32'(bus.out_data), e.data);
          chk("out_idx",  32'(bus.out_idx),  e.idx);
          chk("out_last", 32'(bus.out_last), e.last);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        for (int i = 0; i < 8; i++)
          sb.push_back('{q_model(int'(zr[i]), int'(sr)), i, (i == 7) ? 1 : 0});
        accepted = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic offer();
    bus.in_valid = 1'b1;
    for (int n = 0; n < 20 && !accepted; n++) cycle();
    if (!accepted) fail_now("row_accept");
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && sb.size() != 0; n++) cycle();
    if (sb.size() != 0) begin
      fail_now("drain");
      sb.delete();
    end
  endtask

  task automatic load(input int a0, input int a1, input int a2, input int a3,
                      input int a4, input int a5, input int a6, input int a7, input int s);
    zr[0] = IW'(a0); zr[1] = IW'(a1); zr[2] = IW'(a2); zr[3] = IW'(a3);
    zr[4] = IW'(a4); zr[5] = IW'(a5); zr[6] = IW'(a6); zr[7] = IW'(a7);
    sr = 4'(s);
  endtask

  initial begin
    logic signed [OW-1:0] held;
    int acc_k;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    load(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state
    repeat (3) cycle();
    rst = 1'b0;
    chk("rst_in_ready",  32'(bus.in_ready),  1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data",  32'(bus.out_data),  0);
    chk("rst_out_idx",   32'(bus.out_idx),   0);
    chk("rst_out_last",  32'(bus.out_last),  0);

    // Basic row with rounding and saturation, first output one cycle after accept
    load(1000, -1000, 2000, -2000, 5, -5, 12, -12, 3);
    offer();
    chk("lat_out_valid", 32'(bus.out_valid), 1);
    chk("lat_out_idx",   32'(bus.out_idx),   0);
    chk("basic_z0",      32'(bus.out_data),  125);
    chk("basic_in_ready", 32'(bus.in_ready), 0);
    cycle();
    chk("basic_z1", 32'(bus.out_data), -125);
    cycle();
    chk("basic_z2", 32'(bus.out_data), 127);
    cycle();
    chk("basic_z3", 32'(bus.out_data), -128);
    drain();
    chk("basic_idle", 32'(bus.out_valid), 0);

    // Shift zero passes values through
    load(10, 110, 20, 78, 27, 60, 54, 3, 0);
    offer();
    drain();

    // Backpressure at idx 2
    load(-300, 400, -77, 900, 1, 2, 3, 4, 2);
    offer();
    cycle();
    cycle();
    chk("bp_idx_reach", 32'(bus.out_idx), 2);
    bus.out_ready = 1'b0;
    held = bus.out_data;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("bp_out_valid", 32'(bus.out_valid), 1);
      chk("bp_out_idx",   32'(bus.out_idx),   2);
      chk("bp_out_data",  32'(bus.out_data),  32'(held));
    end
    bus.out_ready = 1'b1;
    drain();

    // Back-to-back rows with no bubble; in_valid held while busy is ignored
    load(1, 2, 3, 4, 5, 6, 7, 8, 0);
    offer();
    load(-1, -2, -3, -4, 100, 200, 300, 400, 1);
    bus.in_valid = 1'b1;
    acc_k = -1;
    for (int k = 0; k < 16; k++) begin
      chk("b2b_out_valid", 32'(bus.out_valid), 1);
      cycle();
      if (accepted) begin
        acc_k = k;
        bus.in_valid = 1'b0;
      end
    end
    chk("b2b_accept_slot", acc_k, 7);
    chk("b2b_idle", 32'(bus.out_valid), 0);
    chk("b2b_queue_empty", sb.size(), 0);
    bus.in_valid = 1'b0;
    drain();

    // Reset mid-row at idx 4
    load(11, 22, 33, 44, 55, 66, 77, 88, 0);
    offer();
    for (int n = 0; n < 20 && bus.out_idx != 3'd4; n++) cycle();
    chk("mid_idx_reach", 32'(bus.out_idx), 4);
    rst = 1'b1;
    cycle();
    sb.delete();
    rst = 1'b0;
    chk("mid_out_valid", 32'(bus.out_valid), 0);
    chk("mid_in_ready",  32'(bus.in_ready),  1);
    chk("mid_out_idx",   32'(bus.out_idx),   0);
    chk("mid_out_data",  32'(bus.out_data),  0);
    load(-9, 8, -7, 6, -5, 4, -3, 2, 0);
    offer();
    chk("post_rst_idx",  32'(bus.out_idx),  0);
    chk("post_rst_data", 32'(bus.out_data), -9);
    drain();

    // Extreme shift
    load(16383, -16384, -16385 + 32768 - 32768, 0, -1, 1, 8191, -8193, 15);
    zr[2] = -15'sd16384 + 15'sd0;
    zr[2] = zr[2] - 15'sd0;
    offer();
    chk("ext_z0", 32'(bus.out_data), 0);
    cycle();
    chk("ext_z1", 32'(bus.out_data), 0);
    drain();

    // Shift 14 brings the negative rail to -1
    load(-16384, 16383, -8192, 8191, -8193, 0, -1, 1, 14);
    offer();
    chk("s14_z0", 32'(bus.out_data), -1);
    drain();

    // Pseudo-random rows at random shifts
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 8; i++) zr[i] = IW'($urandom);
      sr = 4'($urandom_range(0, 15));
      offer();
      drain();
    end

    chk("final_queue_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
